// File: rtl/sram_rw_port_arbiter.sv
// Round-robin req/gnt arbiter for SRAM port 0 (1RW); write done at the grant edge, read rvalid one cycle later.
// A held read response (owner rready low) blocks new read grants; writes are always eligible.
module sram_rw_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [2*(AW+2)-1:0] addr_i,
  input  logic [2*4-1:0]      be_i,
  input  logic [2*DW-1:0]     wdata_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          rvalid_o,
  input  logic [1:0]          rready_i,
  output logic [DW-1:0]       rdata_o,
  output logic                sram_csb0_o,
  output logic                sram_web0_o,
  output logic [3:0]          sram_wmask0_o,
  output logic [AW-1:0]       sram_addr0_o,
  output logic [DW-1:0]       sram_din0_o,
  input  logic [DW-1:0]       sram_dout0_i
);

  localparam int BAW = AW + 2;

  logic          rr_ptr_q,  rr_ptr_d;
  logic          pending_q, pending_d;
  logic          pend_id_q, pend_id_d;
  logic          rvalid_q,  rvalid_d;
  logic          rsp_id_q,  rsp_id_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [DW-1:0] din_q,     din_d;
  logic [3:0]    wmask_q,   wmask_d;

  logic [1:0] rvalid;
  logic [1:0] elig;
  logic       pop, read_ok, any_gnt, win, win_we;
  logic       unused_addr_lsbs;

  // Byte-offset bits never reach the macro: misaligned addresses alias the word.
  assign unused_addr_lsbs = ^{addr_i[1:0], addr_i[BAW+1:BAW]};

  always_comb begin
    rvalid   = {rvalid_q & rsp_id_q, rvalid_q & ~rsp_id_q};
    pop      = |(rvalid & rready_i);
    read_ok  = !pending_q && (!rvalid_q || pop);
    elig     = req_i & (we_i | {2{read_ok}});
    any_gnt  = rst_ni && (elig != 2'b00);
    win      = (elig == 2'b11) ? rr_ptr_q : elig[1];
    win_we   = win ? we_i[1] : we_i[0];
    gnt_o    = any_gnt ? (win ? 2'b10 : 2'b01) : 2'b00;

    addr_d   = addr_q;
    din_d    = din_q;
    wmask_d  = wmask_q;
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      addr_d   = win ? addr_i[BAW+2 +: AW] : addr_i[2 +: AW];
      din_d    = win ? wdata_i[DW +: DW] : wdata_i[0 +: DW];
      wmask_d  = win_we ? (win ? be_i[7:4] : be_i[3:0]) : 4'b0000;
      rr_ptr_d = ~win;
    end

    // A read grant requires !pending_q, so a new read never collides with a capture.
    pending_d = any_gnt && !win_we;
    pend_id_d = pending_d ? win : pend_id_q;
    rvalid_d  = pending_q ? 1'b1 : (pop ? 1'b0 : rvalid_q);
    rsp_id_d  = pending_q ? pend_id_q : rsp_id_q;
    rdata_d   = pending_q ? sram_dout0_i : rdata_q;

    sram_csb0_o   = !any_gnt;
    sram_web0_o   = !(any_gnt && win_we);
    sram_addr0_o  = addr_d;
    sram_din0_o   = din_d;
    sram_wmask0_o = wmask_d;
    rvalid_o      = rvalid;
    rdata_o       = rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q  <= 1'b0;
      pending_q <= 1'b0;
      pend_id_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rsp_id_q  <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      wmask_q   <= 4'b0000;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      pend_id_q <= pend_id_d;
      rvalid_q  <= rvalid_d;
      rsp_id_q  <= rsp_id_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wmask_q   <= wmask_d;
    end
  end

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural SRAM and a read-response scoreboard.
module tb_sram_rw_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, we, gnt, rvalid, rready;
  logic [19:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [31:0] rdata;
  logic        csb, web;
  logic [3:0]  wmask;
  logic [7:0]  sram_addr;
  logic [31:0] din, dout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic id; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  sram_rw_port_arbiter #(.AW(8), .DW(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask), .sram_addr0_o(sram_addr),
    .sram_din0_o(din), .sram_dout0_i(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    dout = 32'h0;
  end

  // Macro port 0: data out registered one cycle after issue.
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[sram_addr][b*8 +: 8] <= din[b*8 +: 8];
      end else begin
        dout <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: reads enqueue the shadow word at grant, responses pop at the accepting cycle.
  always @(negedge clk) begin
    if ((rvalid & rready) != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rvalid", {30'b0, rvalid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rsp_id", {30'b0, rvalid}, e.id ? 32'h2 : 32'h1);
        chk("sb_rsp_data", rdata, e.data);
      end
    end
    if (gnt != 2'b00) begin
      int r;
      chk("gnt_onehot", $countones(gnt), 32'd1);
      r = gnt[1] ? 1 : 0;
      if (we[r]) begin
        for (int b = 0; b < 4; b++)
          if (be[r*4+b]) shadow[addr[r*10+2 +: 8]][b*8 +: 8] = wdata[r*32+b*8 +: 8];
      end else begin
        exp_q.push_back('{id: r[0], data: shadow[addr[r*10+2 +: 8]]});
      end
    end
  end

  task automatic drive(input int r, input logic w, input logic [9:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    req[r]            = 1'b1;
    we[r]             = w;
    addr[r*10 +: 10]  = a;
    be[r*4 +: 4]      = b;
    wdata[r*32 +: 32] = d;
  endtask

  task automatic wait_gnt(input int r, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt[r]) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk(tag, {31'b0, found}, 32'h1);
  endtask

  task automatic release_req;
    @(posedge clk); #1;
    req = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 2'b11; we = 2'b00; addr = '0; be = '0; wdata = '0; rready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {30'b0, gnt}, 32'h0);
      chk("rst_csb", {31'b0, csb}, 32'h1);
      chk("rst_web", {31'b0, web}, 32'h1);
      chk("rst_rvalid", {30'b0, rvalid}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b00; rready = 2'b11;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);

    // Write then read through requester 1
    drive(1, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    wait_gnt(1, "t2_wr_gnt");
    chk("t2_wr_gnt_vec", {30'b0, gnt}, 32'h2);
    chk("t2_wr_addr", {24'b0, sram_addr}, 32'h04);
    chk("t2_wr_wmask", {28'b0, wmask}, 32'hF);
    chk("t2_wr_web", {31'b0, web}, 32'h0);
    chk("t2_wr_din", din, 32'hDEADBEEF);
    release_req();
    @(negedge clk);
    chk("t2_idle_csb", {31'b0, csb}, 32'h1);
    chk("t2_idle_addr_hold", {24'b0, sram_addr}, 32'h04);
    drive(1, 1'b0, 10'h010, 4'h0, 32'h0);
    wait_gnt(1, "t2_rd_gnt");
    chk("t2_rd_web", {31'b0, web}, 32'h1);
    chk("t2_rd_wmask", {28'b0, wmask}, 32'h0);
    release_req();
    @(negedge clk);
    chk("t2_rd_pending", {30'b0, rvalid}, 32'h0);
    @(negedge clk);
    chk("t2_rd_rvalid", {30'b0, rvalid}, 32'h2);
    chk("t2_rd_rdata", rdata, 32'hDEADBEEF);

    // Byte-masked write, misaligned read, no-op write
    drive(0, 1'b1, 10'h010, 4'b0101, 32'h11223344);
    wait_gnt(0, "t3_wr_gnt");
    chk("t3_wr_wmask", {28'b0, wmask}, 32'h5);
    release_req();
    drive(0, 1'b0, 10'h013, 4'h0, 32'h0);
    wait_gnt(0, "t3_rd_gnt");
    chk("t3_rd_misaligned_addr", {24'b0, sram_addr}, 32'h04);
    release_req();
    @(negedge clk);
    @(negedge clk);
    chk("t3_rd_rvalid", {30'b0, rvalid}, 32'h1);
    chk("t3_rd_rdata", rdata, 32'hDE22BE44);
    drive(0, 1'b1, 10'h010, 4'h0, 32'hFFFFFFFF);
    wait_gnt(0, "t3_noop_wr_gnt");
    chk("t3_noop_wmask", {28'b0, wmask}, 32'h0);
    release_req();
    drive(1, 1'b1, 10'h020, 4'hF, 32'hCAFEF00D);
    wait_gnt(1, "t4_setup_wr_gnt");
    release_req();

    // Round robin: continuous reads from both, one grant every other cycle
    @(posedge clk); #1;
    we = 2'b00; addr = {10'h020, 10'h010}; req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk($sformatf("t4_rr_gnt_%0d", i), {30'b0, gnt}, {30'b0, exp_g});
      @(posedge clk); #1;
    end
    req = 2'b00;
    repeat (4) @(posedge clk);

    // Back-pressure: held response blocks reads, not writes
    rready = 2'b10;
    drive(0, 1'b0, 10'h010, 4'h0, 32'h0);
    wait_gnt(0, "t5_rd_gnt");
    release_req();
    @(negedge clk);
    @(negedge clk);
    chk("t5_rvalid", {30'b0, rvalid}, 32'h1);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[19:10] = 10'h020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_hold_gnt_%0d", i), {30'b0, gnt}, 32'h0);
      chk($sformatf("t5_hold_rdata_%0d", i), rdata, 32'hDE22BE44);
      chk($sformatf("t5_hold_rvalid_%0d", i), {30'b0, rvalid}, 32'h1);
      @(posedge clk); #1;
    end
    we[1] = 1'b1; addr[19:10] = 10'h030; be[7:4] = 4'hF; wdata[63:32] = 32'h0BADF00D;
    @(negedge clk);
    chk("t5_wr_gnt", {30'b0, gnt}, 32'h2);
    @(posedge clk); #1;
    req = 2'b00; rready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t5_after_pop_rvalid", {30'b0, rvalid}, 32'h0);

    // Reset in the cycle after a read grant discards the read
    drive(0, 1'b0, 10'h010, 4'h0, 32'h0);
    wait_gnt(0, "t6_rd_gnt");
    @(posedge clk); #1;
    req = 2'b00; rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_rvalid", {30'b0, rvalid}, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_pending_cleared", {31'b0, dut.pending_q}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_no_rvalid_%0d", i), {30'b0, rvalid}, 32'h0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
